seq_pattern_counter: RTL
========================

// Module: seq_pattern_counter
// PURPOSE
//  Serial pattern detector and counter. Samples 1-bit stream DAT on qualified clocks, compares
//  last PAT_W bits against PATTERN, counts matches. Parametrised successor of the fixed 4-bit
//  serial counter: adds configurable pattern/width, overlap vs non-overlap, wrap vs saturate,
//  input qualifier, sync clear, overflow flag. Sits directly behind a serial data pin/deserialiser.
// PARAMETERS
//  PAT_W     4        pattern length in bits (2..16)
//  PATTERN   4'b1010  target sequence; MSB = oldest bit received
//  CNT_W     4        match counter width (1..16)
//  OVERLAP   1        1: matches may share bits; 0: window restarts after each match
//  SATURATE  0        1: counter holds at all-ones; 0: counter wraps to 0
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset (0 = reset)
//  DAT        in   1      serial data bit
//  dat_valid  in   1      DAT sampled only when 1
//  clear      in   1      synchronous clear of counter, window, overflow
//  counter    out  CNT_W  number of matches since reset/clear
//  match      out  1      1-cycle pulse, registered, on each detected match
//  overflow   out  1      sticky; set when a match occurs with counter at all-ones
// BEHAVIOUR
//  - Reset (reset=0, async assert, sync release): counter=0, match=0, overflow=0, window=0,
//    fill=0. Reset mid-stream discards partial pattern; PAT_W fresh valid bits needed first.
//  - Window: on clk rise with dat_valid=1, window <= {window[PAT_W-2:0], DAT};
//    fill <= min(fill+1, PAT_W). dat_valid=0: window, fill, counter hold; match=0.
//  - Match condition: dat_valid=1 and next window == PATTERN and next fill == PAT_W.
//  - Latency: match and counter update on the same edge that samples the completing bit.
//  - match is high exactly one cycle per match; back-to-back matches give consecutive pulses.
//  - OVERLAP=0: on match, fill <= 0 (window contents irrelevant until refilled).
//    OVERLAP=1: fill stays PAT_W; next valid bit may complete another match.
//  - Counter arithmetic CNT_W bits, unsigned. At all-ones + match: SATURATE=0 -> 0,
//    SATURATE=1 -> holds all-ones; overflow <= 1 in both modes.
//  - clear=1: counter=0, overflow=0, fill=0, match=0 next edge; clear beats simultaneous
//    match (that match is not counted and match stays 0).
//  - overflow remains 1 until clear or reset.
//  - No X propagation: DAT ignored when dat_valid=0.
// STRUCTURE
//  - Shared package seq_pkg: default PAT_W/CNT_W constants, default PATTERN, mode encodings
//    (OVL_ON/OVL_OFF, CNT_WRAP/CNT_SAT).
//  - One sub-module seq_window: shift register + fill counter + comparator; outputs hit.
//    Top holds counter, overflow, match register and clear/overlap control.
//  - All state in a single clk domain; no latches; all outputs registered.
// TESTING
//  1 Reset: reset=0 for 2 cycles with DAT toggling -> counter=0, match=0, overflow=0;
//    release, feed 1,0,1 -> no match (fill<4).
//  2 Overlap (defaults): valid bits 1,0,1,0,1,0,1 -> match on bits 4 and 6, counter=2.
//  3 Non-overlap (OVERLAP=0): same 7 bits -> single match on bit 4, counter=1.
//  4 Qualifier: 1,0,[DAT=1,valid=0],1,0 -> bubble ignored, match on last bit, counter=1.
//  5 Wrap/saturate (CNT_W=4): 16 matches -> SATURATE=0: counter=0, overflow=1;
//    SATURATE=1: counter=15, overflow=1; extra match keeps 15.
//  6 Clear collision: assert clear on the edge completing 1010 -> counter=0, match=0,
//    overflow=0; mid-stream reset=0 after 1,0,1 then 0 -> no match.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the serial pattern counter.
// Default geometry, default target pattern and mode encodings.
package seq_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 4;

    localparam logic [3:0] DEF_PATTERN = 4'b1010;

    localparam bit OVL_ON  = 1'b1;
    localparam bit OVL_OFF = 1'b0;

    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

endpackage

// File: rtl/seq_window.sv
// Sliding window over the serial stream.
// Shift register, fill tracker and pattern comparator.
module seq_window
    import seq_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
    input  logic clk,
    input  logic reset,
    input  logic dat,
    input  logic valid,
    input  logic clear,
    input  logic drop,
    output logic hit
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] win;
    logic [PAT_W-1:0] win_nxt;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_nxt;

    // Window as it would look after taking the current bit.
    always_comb begin
        win_nxt  = {win[PAT_W-2:0], dat};
        fill_nxt = (fill == FULL) ? fill : fill + FW'(1);
        hit      = valid && (win_nxt == PATTERN) && (fill_nxt == FULL);
    end

    // Shift in qualified bits; clear or a non-overlapping match empties it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win  <= '0;
            fill <= '0;
        end else if (clear) begin
            win  <= '0;
            fill <= '0;
        end else if (valid) begin
            win  <= win_nxt;
            fill <= drop ? '0 : fill_nxt;
        end
    end

endmodule

// File: rtl/seq_pattern_counter.sv
// Serial pattern detector and match counter.
// Counts pattern hits with wrap or saturate and a sticky overflow.
module seq_pattern_counter
    import seq_pkg::*;
#(
    parameter int               PAT_W    = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN  = PAT_W'(DEF_PATTERN),
    parameter int               CNT_W    = DEF_CNT_W,
    parameter bit               OVERLAP  = OVL_ON,
    parameter bit               SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DAT,
    input  logic             dat_valid,
    input  logic             clear,
    output logic [CNT_W-1:0] counter,
    output logic             match,
    output logic             overflow
);

    logic hit;
    logic drop;
    logic at_max;

    // Without overlap, a match restarts the window from empty.
    always_comb begin
        drop   = hit && (OVERLAP == OVL_OFF);
        at_max = &counter;
    end

    seq_window #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_win (
        .clk   (clk),
        .reset (reset),
        .dat   (DAT),
        .valid (dat_valid),
        .clear (clear),
        .drop  (drop),
        .hit   (hit)
    );

    // Match count, pulse and sticky overflow; clear wins over a hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter  <= '0;
            match    <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            counter  <= '0;
            match    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            match <= hit;
            if (hit) begin
                if (at_max) begin
                    overflow <= 1'b1;
                    if (SATURATE == CNT_WRAP)
                        counter <= '0;
                end else begin
                    counter <= counter + CNT_W'(1);
                end
            end
        end
    end

endmodule
